apb_timer_nch: RTL
==================

Name: apb_timer_nch

Overview:
Parametrised successor of the two-channel APB timer. It provides CH_NUM independent down-counters of CNT_W bits, each with its own prescaler, three count modes (free-run, periodic reload, one-shot), a maskable interrupt, and an ETB start/stop trigger pair. It sits on the peripheral APB bus beside the existing timer. Each channel drives its own interrupt line to the interrupt controller and its own expire-pulse to the ETB.

Parameters:
CH_NUM, 4, number of channels (1..8)
CNT_W, 32, counter and load width (8..32)
PRE_W, 8, prescaler divisor width (1..8)

Ports:
pclk  in  1  APB and timer clock
presetn  in  1  synchronous reset, active-low
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB write
paddr  in  8  APB byte address
pwdata  in  32  APB write data
prdata  out  32  APB read data
etb_trig_en_on  in  CH_NUM  per-channel ETB start pulse
etb_trig_en_off  in  CH_NUM  per-channel ETB stop pulse
etb_trig  out  CH_NUM  per-channel expire pulse, 1 cycle
intr  out  CH_NUM  per-channel interrupt, level, active-high

Behaviour:
- One clock domain. Reset is synchronous and active-low; presetn is sampled on the pclk rising edge.
- Reset state: all registers 0, counters 0, intr=0, etb_trig=0, prdata=0.
- Register map, channel n at base n*0x14:
  - +0x00 LOAD (RW, CNT_W bits, zero-extended on read).
  - +0x04 CURVAL (RO).
  - +0x08 CTRL (RW): [0] EN; [2:1] MODE (0 free, 1 reload, 2 one-shot, 3 reserved, treated as reload); [3] IMASK (1 = masked); [8+PRE_W-1:8] PRE.
  - +0x0C EOI (RO): read returns 0 and clears INT_RAW[n].
  - +0x10 INTSTAT (RO): bit0 = INT_RAW & ~IMASK.
- Global registers:
  - 0xA0 RAWSTAT (RO): INT_RAW vector.
  - 0xA4 STAT (RO): masked vector.
  - 0xA8 EOI_ALL (RO): read returns 0 and clears all INT_RAW.
- Unmapped addresses read 0; writes to them are ignored.
- APB timing: zero wait states. Write commits on the psel&penable&pwrite cycle. prdata is combinational during the psel&~pwrite phase and 0 otherwise. Read side-effects fire only when psel&penable.
- Enable rising edge (APB or ETB): CURVAL <= LOAD and prescale counter <= 0 on the same edge. No tick occurs in that cycle.
- Tick: while EN=1, the prescale counter increments each cycle. When it equals PRE it returns to 0 and the channel ticks, so the divisor is PRE+1.
- On a tick with CURVAL != 0: CURVAL decrements by 1.
- On a tick with CURVAL == 0 (expire):
  - etb_trig[n]=1 for exactly 1 cycle.
  - INT_RAW[n] is set.
  - Mode free: CURVAL <= all-ones.
  - Mode reload: CURVAL <= LOAD.
  - Mode one-shot: CURVAL <= LOAD and EN cleared, so no further ticks.
- LOAD=0 in reload mode expires on every tick.
- Writing LOAD while running has no immediate effect; the new value is used at the next reload or enable edge.
- Writing CTRL with EN=1 while EN is already 1 does not reload the counter.
- EN=0 freezes CURVAL. The prescale counter is held at 0 while EN=0.
- ETB control: etb_trig_en_on sets EN and etb_trig_en_off clears EN.
- Priority for EN, highest first:
  - etb_trig_en_off
  - etb_trig_en_on
  - one-shot auto-clear
  - APB CTRL write
- INT_RAW set and an EOI clear in the same cycle: set wins.
- intr[n] = INT_RAW[n] & ~IMASK[n], registered, so it rises 1 cycle after the expire tick.
- Channel registers for n >= CH_NUM read 0.

Decomposition:
- Package tim_nch_pkg holds:
  - register offset constants: LOAD, CURVAL, CTRL, EOI, INTSTAT, CH_STRIDE=0x14, RAWSTAT, STAT, EOI_ALL
  - CTRL bit positions
  - mode encodings: MODE_FREE, MODE_RELOAD, MODE_ONESHOT
- One sub-module, tim_nch_chan, contains one channel's LOAD, CTRL, prescaler, counter, INT_RAW and expire logic. It is instantiated CH_NUM times via generate.
- The top level holds APB decode, per-channel write strobes, EOI clears and the read mux.

Test Plan:
- Reset, then ch0 LOAD=3, CTRL=0x3 (EN, reload, PRE=0) -> CURVAL sequence 3,2,1,0,3. etb_trig[0] pulses on the 0->3 edge. intr[0] rises 1 cycle later.
- ch1 LOAD=2, MODE one-shot, PRE=1 -> a tick every 2 cycles; expires once; EN reads 0 afterwards; CURVAL=2 and stays frozen.
- ch2 free mode, LOAD=0 -> first tick expires and wraps CURVAL to all-ones; then decrements by 1 per tick.
- Expire and a read of EOI on the same cycle -> INT_RAW stays 1. A following EOI read returns 0 and drops intr the next cycle. With IMASK=1, RAWSTAT=1 and STAT=0.
- etb_trig_en_on and etb_trig_en_off asserted together on ch3 -> EN stays 0. An on pulse alone -> CURVAL loads LOAD. An APB CTRL write with EN=1 in the same cycle as an off pulse -> EN=0.
- presetn low mid-count for 1 cycle -> all outputs and registers 0 at the next edge; counting resumes only after EN is rewritten.

Source files
------------

// File: rtl/tim_nch_pkg.sv
// Shared register map, CTRL field positions and count-mode encodings for the
// multi-channel APB timer.
package tim_nch_pkg;

  localparam logic [7:0] OFF_LOAD     = 8'h00;
  localparam logic [7:0] OFF_CURVAL   = 8'h04;
  localparam logic [7:0] OFF_CTRL     = 8'h08;
  localparam logic [7:0] OFF_EOI      = 8'h0C;
  localparam logic [7:0] OFF_INTSTAT  = 8'h10;
  localparam logic [7:0] CH_STRIDE    = 8'h14;

  localparam logic [7:0] ADDR_RAWSTAT = 8'hA0;
  localparam logic [7:0] ADDR_STAT    = 8'hA4;
  localparam logic [7:0] ADDR_EOI_ALL = 8'hA8;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_MODE_LSB  = 1;
  localparam int unsigned CTRL_IMASK_BIT = 3;
  localparam int unsigned CTRL_PRE_LSB   = 8;

  typedef enum logic [1:0] {
    MODE_FREE    = 2'd0,
    MODE_RELOAD  = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } tim_mode_e;

  function automatic logic [7:0] ch_base(input int unsigned ch);
    return 8'(ch * 32'(CH_STRIDE));
  endfunction

endpackage

// File: rtl/tim_nch_chan.sv
// One timer channel: LOAD/CTRL registers, prescaler, down-counter,
// raw interrupt latch and expire pulse.
module tim_nch_chan
  import tim_nch_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned PRE_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load_we,
  input  logic             i_ctrl_we,
  input  logic [31:0]      i_wdata,
  input  logic             i_eoi_clr,
  input  logic             i_trig_on,
  input  logic             i_trig_off,
  output logic [CNT_W-1:0] o_load,
  output logic [CNT_W-1:0] o_curval,
  output logic [31:0]      o_ctrl,
  output logic             o_int_raw,
  output logic             o_intstat,
  output logic             o_intr,
  output logic             o_etb_trig
);

  logic [CNT_W-1:0] r_load;
  logic [CNT_W-1:0] r_curval;
  logic [CNT_W-1:0] w_curval_d;
  logic             r_en;
  logic             w_en_d;
  logic             w_en_rise;
  tim_mode_e        r_mode;
  logic             r_imask;
  logic [PRE_W-1:0] r_pre;
  logic [PRE_W-1:0] r_pre_cnt;
  logic [PRE_W-1:0] w_pre_cnt_d;
  logic             r_int_raw;
  logic             w_int_raw_d;
  logic             r_intr;
  logic             r_etb_trig;
  logic             w_tick;
  logic             w_expire;

  always_comb begin
    // >= keeps the divider from running a full wrap if PRE is lowered mid-count
    w_tick   = r_en && (r_pre_cnt >= r_pre);
    w_expire = w_tick && (r_curval == '0);

    // Later assignments override earlier ones: lowest priority first.
    w_en_d = r_en;
    if (i_ctrl_we) w_en_d = i_wdata[CTRL_EN_BIT];
    if (w_expire && (r_mode == MODE_ONESHOT)) w_en_d = 1'b0;
    if (i_trig_on) w_en_d = 1'b1;
    if (i_trig_off) w_en_d = 1'b0;
    w_en_rise = w_en_d && !r_en;

    if (!w_en_d || w_en_rise || w_tick) begin
      w_pre_cnt_d = '0;
    end else begin
      w_pre_cnt_d = r_pre_cnt + 1'b1;
    end

    w_curval_d = r_curval;
    if (w_en_rise) begin
      w_curval_d = r_load;
    end else if (w_tick) begin
      if (r_curval != '0) begin
        w_curval_d = r_curval - 1'b1;
      end else begin
        case (r_mode)
          MODE_FREE: w_curval_d = '1;
          default:   w_curval_d = r_load;
        endcase
      end
    end

    w_int_raw_d = r_int_raw;
    if (i_eoi_clr) w_int_raw_d = 1'b0;
    if (w_expire) w_int_raw_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_load     <= '0;
      r_curval   <= '0;
      r_en       <= 1'b0;
      r_mode     <= MODE_FREE;
      r_imask    <= 1'b0;
      r_pre      <= '0;
      r_pre_cnt  <= '0;
      r_int_raw  <= 1'b0;
      r_intr     <= 1'b0;
      r_etb_trig <= 1'b0;
    end else begin
      if (i_load_we) r_load <= i_wdata[CNT_W-1:0];
      if (i_ctrl_we) begin
        r_mode  <= tim_mode_e'(i_wdata[CTRL_MODE_LSB +: 2]);
        r_imask <= i_wdata[CTRL_IMASK_BIT];
        r_pre   <= i_wdata[CTRL_PRE_LSB +: PRE_W];
      end
      r_en       <= w_en_d;
      r_curval   <= w_curval_d;
      r_pre_cnt  <= w_pre_cnt_d;
      r_int_raw  <= w_int_raw_d;
      r_intr     <= r_int_raw & ~r_imask;
      r_etb_trig <= w_expire;
    end
  end

  always_comb begin
    o_ctrl                          = '0;
    o_ctrl[CTRL_EN_BIT]             = r_en;
    o_ctrl[CTRL_MODE_LSB +: 2]      = r_mode;
    o_ctrl[CTRL_IMASK_BIT]          = r_imask;
    o_ctrl[CTRL_PRE_LSB +: PRE_W]   = r_pre;
  end

  assign o_load     = r_load;
  assign o_curval   = r_curval;
  assign o_int_raw  = r_int_raw;
  assign o_intstat  = r_int_raw & ~r_imask;
  assign o_intr     = r_intr;
  assign o_etb_trig = r_etb_trig;

endmodule

// File: rtl/apb_timer_nch.sv
// APB front end for CH_NUM independent timer channels: address decode,
// per-channel write/EOI strobes and the combinational read mux.
module apb_timer_nch
  import tim_nch_pkg::*;
#(
  parameter int unsigned CH_NUM = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned PRE_W  = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [7:0]        paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  input  logic [CH_NUM-1:0] etb_trig_en_on,
  input  logic [CH_NUM-1:0] etb_trig_en_off,
  output logic [CH_NUM-1:0] etb_trig,
  output logic [CH_NUM-1:0] intr
);

  logic              w_apb_wr;
  logic              w_apb_rd_fx;
  logic              w_eoi_all;
  logic [CH_NUM-1:0] w_ch_hit;
  logic [7:0]        w_ch_off;
  logic [CH_NUM-1:0] w_load_we;
  logic [CH_NUM-1:0] w_ctrl_we;
  logic [CH_NUM-1:0] w_eoi_clr;
  logic [CH_NUM-1:0] w_int_raw;
  logic [CH_NUM-1:0] w_intstat;
  logic [CNT_W-1:0]  w_load   [CH_NUM];
  logic [CNT_W-1:0]  w_curval [CH_NUM];
  logic [31:0]       w_ctrl   [CH_NUM];

  assign w_apb_wr    = psel & penable & pwrite;
  assign w_apb_rd_fx = psel & penable & ~pwrite;
  assign w_eoi_all   = w_apb_rd_fx && (paddr == ADDR_EOI_ALL);

  // Channel windows are disjoint, so at most one hit bit is set.
  always_comb begin
    w_ch_hit = '0;
    w_ch_off = '0;
    for (int unsigned n = 0; n < CH_NUM; n++) begin
      if ((paddr >= ch_base(n)) && (paddr < ch_base(n) + CH_STRIDE)) begin
        w_ch_hit[n] = 1'b1;
        w_ch_off    = paddr - ch_base(n);
      end
    end
  end

  always_comb begin
    w_load_we = '0;
    w_ctrl_we = '0;
    w_eoi_clr = '0;
    for (int unsigned n = 0; n < CH_NUM; n++) begin
      w_load_we[n] = w_apb_wr & w_ch_hit[n] & (w_ch_off == OFF_LOAD);
      w_ctrl_we[n] = w_apb_wr & w_ch_hit[n] & (w_ch_off == OFF_CTRL);
      w_eoi_clr[n] = w_eoi_all | (w_apb_rd_fx & w_ch_hit[n] & (w_ch_off == OFF_EOI));
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    tim_nch_chan #(
      .CNT_W (CNT_W),
      .PRE_W (PRE_W)
    ) u_chan (
      .i_clk      (pclk),
      .i_rst_n    (presetn),
      .i_load_we  (w_load_we[g]),
      .i_ctrl_we  (w_ctrl_we[g]),
      .i_wdata    (pwdata),
      .i_eoi_clr  (w_eoi_clr[g]),
      .i_trig_on  (etb_trig_en_on[g]),
      .i_trig_off (etb_trig_en_off[g]),
      .o_load     (w_load[g]),
      .o_curval   (w_curval[g]),
      .o_ctrl     (w_ctrl[g]),
      .o_int_raw  (w_int_raw[g]),
      .o_intstat  (w_intstat[g]),
      .o_intr     (intr[g]),
      .o_etb_trig (etb_trig[g])
    );
  end

  // EOI and EOI_ALL fall through to 0, as do unmapped addresses.
  always_comb begin
    prdata = '0;
    if (psel && !pwrite) begin
      case (paddr)
        ADDR_RAWSTAT: prdata = 32'(w_int_raw);
        ADDR_STAT:    prdata = 32'(w_intstat);
        default:      ;
      endcase
      for (int unsigned n = 0; n < CH_NUM; n++) begin
        if (w_ch_hit[n]) begin
          case (w_ch_off)
            OFF_LOAD:    prdata = 32'(w_load[n]);
            OFF_CURVAL:  prdata = 32'(w_curval[n]);
            OFF_CTRL:    prdata = w_ctrl[n];
            OFF_INTSTAT: prdata = 32'(w_intstat[n]);
            default:     ;
          endcase
        end
      end
    end
  end

endmodule
